// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: icache port (i_*), dcache port (d_*) and the shared pmem line port.
// The slave modport is the arbiter's view; master is the view of the surrounding caches and memory.
interface mem_port_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one pmem line port between icache (I) and dcache (D); D has priority, bounded by a starvation limit.
// Define ARB_PERF_CNT_EN to add the perf_i_grants / perf_d_grants / perf_conflicts counters.
module mem_port_arbiter #(
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts,
`endif
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_I   = 2'd1,
        GNT_D   = 2'd2,
        RECOVER = 2'd3
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= STARVE_MAX) ? STARVE_MAX : (v + 4'd1);
    endfunction

    state_e                state_q, state_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;

    logic                  d_req_s;
    logic                  grant_d_s;
    logic                  grant_i_s;

    // Arbitration decision on this cycle's requests; grants only happen from IDLE.
    always_comb begin
        d_req_s   = bus.d_read | bus.d_write;
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_q == IDLE) begin
            if (d_req_s && (!bus.i_read || (starve_cnt_q < STARVE_MAX))) begin
                grant_d_s = 1'b1;
            end else if (bus.i_read) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        i_resp_d       = 1'b0;
        d_resp_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d_s) begin
                    state_d        = GNT_D;
                    pmem_address_d = bus.d_address;
                    pmem_wdata_d   = bus.d_wdata;
                    // A simultaneous read+write is treated as a write-back only.
                    pmem_write_d   = bus.d_write;
                    pmem_read_d    = bus.d_read & ~bus.d_write;
                    if (bus.i_read) begin
                        starve_cnt_d = sat_inc(starve_cnt_q);
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else if (grant_i_s) begin
                    state_d        = GNT_I;
                    pmem_address_d = bus.i_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                    starve_cnt_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_I: begin
                if (bus.pmem_resp) begin
                    i_rdata_d    = bus.pmem_rdata;
                    i_resp_d     = 1'b1;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = RECOVER;
                end else begin
                    state_d = GNT_I;
                end
            end
            GNT_D: begin
                if (bus.pmem_resp) begin
                    if (pmem_read_q) begin
                        d_rdata_d = bus.pmem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    d_resp_d     = 1'b1;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = RECOVER;
                end else begin
                    state_d = GNT_D;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            starve_cnt_q   <= 4'd0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= {ADDR_WIDTH{1'b0}};
            pmem_wdata_q   <= {LINE_WIDTH{1'b0}};
            i_rdata_q      <= {LINE_WIDTH{1'b0}};
            d_rdata_q      <= {LINE_WIDTH{1'b0}};
            i_resp_q       <= 1'b0;
            d_resp_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            i_resp_q       <= i_resp_d;
            d_resp_q       <= d_resp_d;
        end
    end

    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.i_resp       = i_resp_q;
    assign bus.d_resp       = d_resp_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_grants_q, perf_i_grants_d;
    logic [31:0] perf_d_grants_q, perf_d_grants_d;
    logic [31:0] perf_conflicts_q, perf_conflicts_d;

    // Grant and contention counters; they wrap naturally at 2^32.
    always_comb begin
        perf_i_grants_d  = perf_i_grants_q;
        perf_d_grants_d  = perf_d_grants_q;
        perf_conflicts_d = perf_conflicts_q;
        if (grant_i_s) begin
            perf_i_grants_d = perf_i_grants_q + 32'd1;
        end else begin
            perf_i_grants_d = perf_i_grants_q;
        end
        if (grant_d_s) begin
            perf_d_grants_d = perf_d_grants_q + 32'd1;
        end else begin
            perf_d_grants_d = perf_d_grants_q;
        end
        if ((state_q == IDLE) && bus.i_read && d_req_s) begin
            perf_conflicts_d = perf_conflicts_q + 32'd1;
        end else begin
            perf_conflicts_d = perf_conflicts_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_i_grants_q  <= 32'd0;
            perf_d_grants_q  <= 32'd0;
            perf_conflicts_q <= 32'd0;
        end else begin
            perf_i_grants_q  <= perf_i_grants_d;
            perf_d_grants_q  <= perf_d_grants_d;
            perf_conflicts_q <= perf_conflicts_d;
        end
    end

    assign perf_i_grants  = perf_i_grants_q;
    assign perf_d_grants  = perf_d_grants_q;
    assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    mem_port_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
`ifdef ARB_PERF_CNT_EN
        .perf_i_grants (perf_i_grants),
        .perf_d_grants (perf_d_grants),
        .perf_conflicts(perf_conflicts),
`endif
        .bus           (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // requester / memory stimulus state
    logic          ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] dwd;
    bit            i_hold, d_hold;
    int            i_prob, d_prob, dmode;
    int            lat_cfg, strobe_cnt;
    bit            lat_rand, stray_en, use_pat, prev_strobe;
    logic [LW-1:0] pat;
    int            n_rd, n_wr, n_ir, n_dr;
    bit            glog[$];

    // reference model: one transfer at a time, one idle cycle after each completion
    bit            m_busy, m_owner_d, m_wr, m_iresp, m_dresp;
    int            m_cool, m_streak;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_irdata, m_drdata;
    int unsigned   m_pi, m_pd, m_pc;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr(input bit top);
        logic [AW-1:0] a;
        a = $urandom();
        a[4:0] = 5'd0;
        a[AW-1] = top;
        return a;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_owner_d = 0; m_wr = 0; m_iresp = 0; m_dresp = 0;
        m_cool = 0; m_streak = 0;
        m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
        m_pi = 0; m_pd = 0; m_pc = 0;
    endfunction

    function automatic void model_update(input logic r_i, input logic r_dr, input logic r_dw,
                                         input logic [AW-1:0] a_i, input logic [AW-1:0] a_d,
                                         input logic [LW-1:0] wd, input logic presp,
                                         input logic [LW-1:0] prd);
        m_iresp = 0;
        m_dresp = 0;
        if (m_busy) begin
            if (presp) begin
                if (m_owner_d) begin
                    if (!m_wr) m_drdata = prd;
                    m_dresp = 1;
                end else begin
                    m_irdata = prd;
                    m_iresp = 1;
                end
                m_busy = 0;
                m_cool = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            if (r_i && (r_dr || r_dw)) m_pc++;
            if ((r_dr || r_dw) && (!r_i || m_streak < SL)) begin
                m_busy = 1; m_owner_d = 1; m_wr = r_dw; m_addr = a_d; m_wdata = wd; m_pd++;
                if (r_i) m_streak = (m_streak + 1 > SL) ? SL : m_streak + 1;
            end else if (r_i) begin
                m_busy = 1; m_owner_d = 0; m_wr = 0; m_addr = a_i; m_pi++; m_streak = 0;
            end
        end
    endfunction

    // One clock: drive at negedge, check 1 time unit after posedge, return at the next negedge.
    task automatic step();
        logic          s_presp;
        logic [LW-1:0] s_prd;
        bit            cur;
        if (i_hold) i_hold = 0;
        else if (!ir && ($urandom_range(1, 100) <= i_prob)) begin ir = 1; ia = rand_addr(1'b0); end
        if (d_hold) d_hold = 0;
        else if (!dr && !dw && ($urandom_range(1, 100) <= d_prob)) begin
            case ((dmode == 3) ? int'($urandom_range(0, 2)) : dmode)
                0: begin dr = 1; dw = 0; end
                1: begin dr = 0; dw = 1; end
                default: begin dr = 1; dw = 1; end
            endcase
            da = rand_addr(1'b1);
            dwd = rand_line();
        end
        if (bus.pmem_read || bus.pmem_write) strobe_cnt++; else strobe_cnt = 0;
        if (strobe_cnt == 1 && lat_rand) lat_cfg = $urandom_range(1, 6);
        s_presp = 1'b0;
        if (strobe_cnt != 0 && strobe_cnt == lat_cfg) s_presp = 1'b1;
        else if (stray_en && !m_busy && $urandom_range(0, 7) == 0) s_presp = 1'b1;
        s_prd = (s_presp && use_pat) ? pat : rand_line();
        bus.i_read = ir; bus.i_address = ia;
        bus.d_read = dr; bus.d_write = dw; bus.d_address = da; bus.d_wdata = dwd;
        bus.pmem_resp = s_presp; bus.pmem_rdata = s_prd;

        @(posedge clk);
        #1;
        model_update(ir, dr, dw, ia, da, dwd, s_presp, s_prd);
        check_eq("pmem_read", 256'(bus.pmem_read), 256'(m_busy && !m_wr));
        check_eq("pmem_write", 256'(bus.pmem_write), 256'(m_busy && m_wr));
        check_eq("pmem_address", 256'(bus.pmem_address), 256'(m_addr));
        check_eq("pmem_wdata", bus.pmem_wdata, m_wdata);
        check_eq("i_rdata", bus.i_rdata, m_irdata);
        check_eq("d_rdata", bus.d_rdata, m_drdata);
        check_eq("i_resp", 256'(bus.i_resp), 256'(m_iresp));
        check_eq("d_resp", 256'(bus.d_resp), 256'(m_dresp));
        check_eq("resp_excl", 256'(bus.i_resp & bus.d_resp), 256'(1'b0));
`ifdef ARB_PERF_CNT_EN
        check_eq("perf_i", 256'(perf_i_grants), 256'(m_pi));
        check_eq("perf_d", 256'(perf_d_grants), 256'(m_pd));
        check_eq("perf_conf", 256'(perf_conflicts), 256'(m_pc));
`endif
        n_rd += int'(bus.pmem_read);
        n_wr += int'(bus.pmem_write);
        n_ir += int'(bus.i_resp);
        n_dr += int'(bus.d_resp);
        cur = bus.pmem_read | bus.pmem_write;
        if (cur && !prev_strobe) begin
            glog.push_back(bus.pmem_address[AW-1]);
            if (!bus.pmem_address[AW-1]) check_eq("starve_clr", 256'(dut.starve_cnt_q), 256'(4'd0));
        end
        prev_strobe = cur;
        if (bus.i_resp) begin ir = 0; i_hold = 1; end
        if (bus.d_resp) begin dr = 0; dw = 0; d_hold = 1; end
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        ir = 0; dr = 0; dw = 0; i_hold = 0; d_hold = 0;
        strobe_cnt = 0; prev_strobe = 0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic clear_counts();
        n_rd = 0; n_wr = 0; n_ir = 0; n_dr = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_seq [10];
        i_prob = 0; d_prob = 0; dmode = 0; lat_cfg = 4; lat_rand = 0; stray_en = 0; use_pat = 0;
        ia = '0; da = '0; dwd = '0; pat = '0;
        apply_reset();

        check_eq("rst_pmem_read", 256'(bus.pmem_read), 256'(1'b0));
        check_eq("rst_pmem_write", 256'(bus.pmem_write), 256'(1'b0));
        check_eq("rst_pmem_address", 256'(bus.pmem_address), 256'(32'h0));
        check_eq("rst_pmem_wdata", bus.pmem_wdata, 256'(0));
        check_eq("rst_i_rdata", bus.i_rdata, 256'(0));
        check_eq("rst_d_rdata", bus.d_rdata, 256'(0));
        check_eq("rst_i_resp", 256'(bus.i_resp), 256'(1'b0));
        check_eq("rst_d_resp", 256'(bus.d_resp), 256'(1'b0));

        // single I read: strobe 4 cycles, one i_resp, patterned data
        clear_counts();
        pat = {8{32'hDEAD_BEEF}}; use_pat = 1; lat_cfg = 4;
        ir = 1; ia = 32'h0000_0040;
        repeat (10) step();
        use_pat = 0;
        check_eq("t1_read_cycles", 256'(n_rd), 256'(4));
        check_eq("t1_i_resp_cnt", 256'(n_ir), 256'(1));
        check_eq("t1_d_resp_cnt", 256'(n_dr), 256'(0));
        check_eq("t1_i_rdata", bus.i_rdata, {8{32'hDEAD_BEEF}});

        // D write-back
        clear_counts();
        dw = 1; dr = 0; da = 32'h0000_1000; dwd = {32{8'hA5}};
        step();
        check_eq("t2_pmem_write", 256'(bus.pmem_write), 256'(1'b1));
        check_eq("t2_pmem_address", 256'(bus.pmem_address), 256'(32'h0000_1000));
        check_eq("t2_pmem_wdata", bus.pmem_wdata, {32{8'hA5}});
        repeat (9) step();
        check_eq("t2_d_resp_cnt", 256'(n_dr), 256'(1));
        check_eq("t2_d_rdata_kept", bus.d_rdata, 256'(0));

        // contended: both ports always requesting
        apply_reset();
        glog.delete();
        i_prob = 100; d_prob = 100; dmode = 0; lat_cfg = 2;
        for (int c = 0; c < 300 && glog.size() < 10; c++) step();
        check_eq("t3_grant_count", 256'(glog.size()), 256'(10));
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 10; k++) begin
            if (k < glog.size()) check_eq($sformatf("t3_grant%0d", k), 256'(glog[k]), 256'(exp_seq[k]));
        end
`ifdef ARB_PERF_CNT_EN
        check_eq("t3_perf_d", 256'(perf_d_grants), 256'(32'd8));
        check_eq("t3_perf_i", 256'(perf_i_grants), 256'(32'd2));
        check_eq("t3_perf_conf", 256'(perf_conflicts), 256'(32'd10));
`endif
        i_prob = 0; d_prob = 0;
        repeat (30) step();

        // simultaneous d_read and d_write: write only
        clear_counts();
        dr = 1; dw = 1; da = 32'h8000_0100; dwd = rand_line(); lat_cfg = 3;
        repeat (10) step();
        check_eq("t4_read_cycles", 256'(n_rd), 256'(0));
        check_eq("t4_write_cycles", 256'(n_wr), 256'(3));
        check_eq("t4_d_resp_cnt", 256'(n_dr), 256'(1));

        // async reset mid D write, pending I granted afterwards
        apply_reset();
        lat_cfg = 50;
        ir = 1; ia = 32'h0000_2000;
        dw = 1; dr = 0; da = 32'h8000_3000; dwd = rand_line();
        step();
        step();
        check_eq("t5_write_before", 256'(bus.pmem_write), 256'(1'b1));
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t5_write_async", 256'(bus.pmem_write), 256'(1'b0));
        check_eq("t5_no_d_resp", 256'(bus.d_resp), 256'(1'b0));
        dw = 0; bus.d_write = 1'b0;
        model_reset();
        strobe_cnt = 0; prev_strobe = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("t5_idle_read", 256'(bus.pmem_read), 256'(1'b0));
        check_eq("t5_idle_addr", 256'(bus.pmem_address), 256'(32'h0));
        clear_counts();
        lat_cfg = 3;
        step();
        check_eq("t5_i_granted", 256'(bus.pmem_read), 256'(1'b1));
        check_eq("t5_i_addr", 256'(bus.pmem_address), 256'(32'h0000_2000));
        repeat (8) step();
        check_eq("t5_i_resp_cnt", 256'(n_ir), 256'(1));
        check_eq("t5_d_resp_cnt", 256'(n_dr), 256'(0));

        // random traffic with random latencies and stray pmem_resp
        i_prob = 30; d_prob = 30; dmode = 3; lat_rand = 1; stray_en = 1;
        repeat (3000) step();
        i_prob = 0; d_prob = 0; stray_en = 0;
        repeat (30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical-memory line port between the instruction cache (port a, IF stage) and the data cache (port b, MEM stage) of the pipelined RV32I core.
- Grants one requester at a time, drives registered request signals to pmem, and routes pmem_rdata/pmem_resp back to the granted cache.
- Data port has priority, bounded by a starvation limit so instruction fetch always progresses.

Parameters:
LINE_WIDTH, 256, cache line width in bits for rdata/wdata.
ADDR_WIDTH, 32, byte address width.
STARVE_LIMIT, 4, consecutive contended D grants before I is forced (1..15).

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
i_read  input  1  icache line read request, held until i_resp
i_address  input  ADDR_WIDTH  icache line address
i_rdata  output  LINE_WIDTH  line returned to icache
i_resp  output  1  icache transfer complete, one-cycle pulse
d_read  input  1  dcache line read request, held until d_resp
d_write  input  1  dcache line write-back request, held until d_resp
d_address  input  ADDR_WIDTH  dcache line address
d_wdata  input  LINE_WIDTH  dcache write-back line
d_rdata  output  LINE_WIDTH  line returned to dcache
d_resp  output  1  dcache transfer complete, one-cycle pulse
pmem_read  output  1  registered read strobe to pmem
pmem_write  output  1  registered write strobe to pmem
pmem_address  output  ADDR_WIDTH  registered pmem address
pmem_wdata  output  LINE_WIDTH  registered pmem write data
pmem_rdata  input  LINE_WIDTH  pmem read data, valid with pmem_resp
pmem_resp  input  1  pmem transfer complete

Behaviour:
- Clock clk; reset reset_n is asynchronous, active-low. Reset forces state IDLE, starve_cnt=0 and all outputs 0: pmem_read, pmem_write, pmem_address, pmem_wdata, i_rdata, d_rdata, i_resp, d_resp.
- States: IDLE, GNT_I, GNT_D, RECOVER.
- IDLE, arbitration on that cycle's request inputs:
  - d_req = d_read|d_write. If d_req and (!i_read or starve_cnt<STARVE_LIMIT): go GNT_D. Else if i_read: go GNT_I. Else stay.
  - On the transition edge, latch address into pmem_address; for D latch d_wdata into pmem_wdata.
  - Set pmem_read (I, or D with d_read only) or pmem_write (D with d_write). If d_read and d_write are both high, the write wins and only pmem_write asserts.
  - First pmem strobe is visible one cycle after the request is sampled.
- starve_cnt: +1 (saturating at STARVE_LIMIT) when D is granted while i_read is high; cleared when I is granted.
- GNT_x: hold all pmem outputs stable. On pmem_resp:
  - Register pmem_rdata into the granted port's rdata (for reads only; rdata is unchanged on writes).
  - Pulse that port's resp for exactly one cycle (the cycle after pmem_resp).
  - Deassert pmem_read/pmem_write on the same edge and go RECOVER.
- RECOVER: one cycle, no new grant. The requester drops its request while resp is high. Then go IDLE.
  - Minimum turnaround: request-to-strobe 1 cycle, pmem_resp-to-resp 1 cycle, back-to-back grants 3 cycles apart.
- Non-granted requests are ignored and must be held by the requester. A request deasserted mid-grant is protocol error; the transfer still completes.
- The other port's resp is never asserted. Both resp signals are never high together.
- pmem_resp outside GNT_I/GNT_D is ignored.
- Async reset mid-transfer abandons it immediately with no resp, and pmem strobes drop asynchronously.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_i_grants, perf_d_grants, perf_conflicts (32 bits each, reset 0, wrap at 2^32).
  - perf_i_grants / perf_d_grants increment on each grant edge.
  - perf_conflicts increments on each IDLE cycle where i_read and d_req are both high.
- Undefined: ports and counters absent; arbitration identical.

Test Plan:
- Single I read, pmem_resp 3 cycles after pmem_read → pmem_read high cycles 1-4, i_rdata=pmem_rdata (0xDEAD_BEEF pattern), one-cycle i_resp, d_resp stays 0.
- D write 0x0000_1000 with d_wdata=0xA5.. → pmem_write=1, pmem_address=0x1000, pmem_wdata=0xA5.., d_resp one cycle, d_rdata unchanged.
- i_read and d_read held continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt=0 after each I grant.
- d_read and d_write both high → only pmem_write asserts; d_resp once.
- reset_n low while in GNT_D with pmem_write high → pmem_write 0 without waiting for clk edge, no d_resp, IDLE after release; pending i_read granted next.
- With ARB_PERF_CNT_EN, 10 contended grants above → perf_d_grants=8, perf_i_grants=2, perf_conflicts=10.
